// File: rtl/bus_host_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_host_rr_arbiter
// Description : Round-robin arbiter sharing one req/gnt/rvalid device port
//               among several hosts, one outstanding access, with a response
//               timeout that turns a hung access into an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_host_rr_arbiter #(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [DataWidth-1:0]                   host_rdata_o,
    output logic [NrHosts-1:0]                     host_err_o,
    output logic                                   device_req_o,
    input  logic                                   device_gnt_i,
    output logic [AddressWidth-1:0]                device_addr_o,
    output logic                                   device_we_o,
    output logic [DataWidth/8-1:0]                 device_be_o,
    output logic [DataWidth-1:0]                   device_wdata_o,
    input  logic                                   device_rvalid_i,
    input  logic [DataWidth-1:0]                   device_rdata_i,
    input  logic                                   device_err_i,
    output logic                                   timeout_o
);

    localparam int c_idx_w = $clog2(NrHosts);
    localparam int c_cnt_w = $clog2(TimeoutCycles + 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    localparam logic [c_idx_w-1:0] c_ptr_rst  = c_idx_w'(NrHosts - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TimeoutCycles - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(TimeoutCycles);

    logic [0:0]         r_state, w_state_nxt;
    logic [c_idx_w-1:0] r_ptr,   w_ptr_nxt;
    logic [c_idx_w-1:0] r_idx,   w_idx_nxt;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;

    logic               w_found;
    logic [c_idx_w-1:0] w_winner;
    logic [c_idx_w-1:0] w_cand;

    // Search upward from the host after the last winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NrHosts; i++) begin
            w_cand = c_idx_w'((int'(r_ptr) + i) % NrHosts);
            if (!w_found && host_req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
            r_ptr   <= c_ptr_rst;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_rdata_o   = '0;
        host_err_o     = '0;
        device_req_o   = 1'b0;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = '0;
        device_wdata_o = '0;
        timeout_o      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    device_req_o         = 1'b1;
                    device_addr_o        = host_addr_i[w_winner];
                    device_we_o          = host_we_i[w_winner];
                    device_be_o          = host_be_i[w_winner];
                    device_wdata_o       = host_wdata_i[w_winner];
                    host_gnt_o[w_winner] = device_gnt_i;
                    if (device_gnt_i) begin
                        w_state_nxt = c_st_wait;
                        w_ptr_nxt   = w_winner;
                        w_idx_nxt   = w_winner;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            c_st_wait: begin
                if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
                // A real response in the timeout cycle takes precedence.
                if (device_rvalid_i) begin
                    host_rvalid_o[r_idx] = 1'b1;
                    host_rdata_o         = device_rdata_i;
                    host_err_o[r_idx]    = device_err_i;
                    w_state_nxt          = c_st_idle;
                end else if (r_cnt == c_cnt_last) begin
                    host_rvalid_o[r_idx] = 1'b1;
                    host_err_o[r_idx]    = 1'b1;
                    timeout_o            = 1'b1;
                    w_state_nxt          = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase

        // Outputs are quiet while reset is held, even with requests pending.
        if (!rst_ni) begin
            host_gnt_o     = '0;
            host_rvalid_o  = '0;
            host_rdata_o   = '0;
            host_err_o     = '0;
            device_req_o   = 1'b0;
            device_addr_o  = '0;
            device_we_o    = 1'b0;
            device_be_o    = '0;
            device_wdata_o = '0;
            timeout_o      = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_host_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_host_rr_arbiter
// Description : Directed self-checking bench for bus_host_rr_arbiter with a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_host_rr_arbiter;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NH-1:0]            host_req, host_gnt, host_we, host_rvalid, host_err;
    logic [NH-1:0][AW-1:0]    host_addr;
    logic [NH-1:0][DW/8-1:0]  host_be;
    logic [NH-1:0][DW-1:0]    host_wdata;
    logic [DW-1:0]            host_rdata;
    logic                     device_req, device_gnt, device_we, device_rvalid, device_err;
    logic [AW-1:0]            device_addr;
    logic [DW/8-1:0]          device_be;
    logic [DW-1:0]            device_wdata, device_rdata;
    logic                     timeout;

    bus_host_rr_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
        .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
        .device_req_o(device_req), .device_gnt_i(device_gnt), .device_addr_o(device_addr),
        .device_we_o(device_we), .device_be_o(device_be), .device_wdata_o(device_wdata),
        .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata),
        .device_err_i(device_err), .timeout_o(timeout)
    );

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    int   errors;
    int   checks;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int h, input logic [31:0] d, input logic e);
        rsp_t x;
        x.host  = h;
        x.rdata = d;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    task automatic sample_rsp(input string tag, input bit exp_valid);
        rsp_t        e;
        logic [63:0] vmask;
        if (!exp_valid) begin
            check({tag, "_no_rvalid"}, 64'(host_rvalid), 64'd0);
        end else if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_underflow: observed rvalid=%b expected a queued response", tag, host_rvalid);
        end else begin
            e     = sb_q.pop_front();
            vmask = 64'd1 << e.host;
            check({tag, "_rvalid"}, 64'(host_rvalid), vmask);
            check({tag, "_rdata"},  64'(host_rdata),  64'(e.rdata));
            check({tag, "_err"},    64'(host_err),    e.err ? vmask : 64'd0);
        end
    endtask

    task automatic clear_inputs();
        host_req      = '0;
        host_addr     = '0;
        host_we       = '0;
        host_be       = '0;
        host_wdata    = '0;
        device_gnt    = 1'b0;
        device_rvalid = 1'b0;
        device_rdata  = '0;
        device_err    = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},    64'(host_gnt),    64'd0);
        check({tag, "_rvalid"}, 64'(host_rvalid), 64'd0);
        check({tag, "_rdata"},  64'(host_rdata),  64'd0);
        check({tag, "_dreq"},   64'(device_req),  64'd0);
        check({tag, "_daddr"},  64'(device_addr), 64'd0);
        check({tag, "_dwdata"}, 64'(device_wdata), 64'd0);
        check({tag, "_timeout"}, 64'(timeout),    64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected $finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [31:0] tag;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset with requests and a response pending: everything stays quiet.
        host_req = 2'b11; device_gnt = 1'b1; host_addr[0] = 32'h0000_0123;
        host_wdata[0] = 32'hFFFF_0000; device_rvalid = 1'b1; device_rdata = 32'h1;
        #1 check_quiet("reset");
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;

        // Host 0 write, one-cycle response.
        @(negedge clk);
        host_req = 2'b01; host_addr[0] = 32'h0010_0000; host_we[0] = 1'b1;
        host_be[0] = 4'hF; host_wdata[0] = 32'h1234_5678; device_gnt = 1'b1;
        #1;
        check("t1_gnt", 64'(host_gnt), 64'h1);
        check("t1_dreq", 64'(device_req), 64'h1);
        check("t1_daddr", 64'(device_addr), 64'h0010_0000);
        check("t1_dwe", 64'(device_we), 64'h1);
        check("t1_dbe", 64'(device_be), 64'hF);
        check("t1_dwdata", 64'(device_wdata), 64'h1234_5678);
        sample_rsp("t1_grant", 1'b0);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0; device_rvalid = 1'b1; device_rdata = '0;
        push(0, 32'h0, 1'b0);
        #1;
        check("t1_wait_dreq", 64'(device_req), 64'h0);
        check("t1_wait_daddr", 64'(device_addr), 64'h0);
        sample_rsp("t1_rsp", 1'b1);

        // Device stalls the grant; host 1 arrives and is next by pointer.
        @(negedge clk);
        clear_inputs();
        host_req = 2'b01; host_addr[0] = 32'h0000_3000; host_addr[1] = 32'h0000_3100;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_stall_gnt", 64'(host_gnt), 64'h0);
            check("t3_stall_dreq", 64'(device_req), 64'h1);
            check("t3_stall_daddr", 64'(device_addr), 64'h0000_3000);
            @(negedge clk);
        end
        host_req = 2'b11;
        #1;
        check("t3_takeover_daddr", 64'(device_addr), 64'h0000_3100);
        check("t3_takeover_gnt", 64'(host_gnt), 64'h0);
        @(negedge clk);
        device_gnt = 1'b1;
        #1 check("t3_gnt", 64'(host_gnt), 64'h2);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0; device_rvalid = 1'b1; device_rdata = 32'h0000_3101;
        push(1, 32'h0000_3101, 1'b0);
        #1 sample_rsp("t3_rsp", 1'b1);

        // Error response to host 1.
        @(negedge clk);
        clear_inputs();
        host_req = 2'b10; host_addr[1] = 32'h0000_5000; device_gnt = 1'b1;
        #1 check("t5_gnt", 64'(host_gnt), 64'h2);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0; device_rvalid = 1'b1;
        device_rdata = 32'hDEAD_BEEF; device_err = 1'b1;
        push(1, 32'hDEAD_BEEF, 1'b1);
        #1;
        sample_rsp("t5_rsp", 1'b1);
        check("t5_timeout", 64'(timeout), 64'h0);

        // Device never answers: forced error on the 4th wait cycle.
        @(negedge clk);
        clear_inputs();
        host_req = 2'b01; host_addr[0] = 32'h0000_4000; device_gnt = 1'b1;
        #1 check("t4_gnt", 64'(host_gnt), 64'h1);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0; device_rdata = 32'hFFFF_FFFF;
        for (int w = 1; w < TO; w++) begin
            #1;
            sample_rsp("t4_wait", 1'b0);
            check("t4_wait_timeout", 64'(timeout), 64'h0);
            @(negedge clk);
        end
        push(0, 32'h0, 1'b1);
        #1;
        sample_rsp("t4_to", 1'b1);
        check("t4_to_pulse", 64'(timeout), 64'h1);
        @(negedge clk);
        #1;
        check("t4_after_timeout", 64'(timeout), 64'h0);
        sample_rsp("t4_after", 1'b0);
        @(negedge clk);
        device_rvalid = 1'b1; device_rdata = 32'h0000_5555;
        #1;
        sample_rsp("t4_late", 1'b0);
        check("t4_late_timeout", 64'(timeout), 64'h0);

        // Response in the timeout cycle wins over the timeout.
        @(negedge clk);
        clear_inputs();
        host_req = 2'b10; host_addr[1] = 32'h0000_6000; device_gnt = 1'b1;
        #1 check("t4b_gnt", 64'(host_gnt), 64'h2);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0;
        repeat (TO - 1) @(negedge clk);
        device_rvalid = 1'b1; device_rdata = 32'h0000_0077;
        push(1, 32'h0000_0077, 1'b0);
        #1;
        sample_rsp("t4b_rsp", 1'b1);
        check("t4b_timeout", 64'(timeout), 64'h0);

        // Fairness after reset: both hosts requesting, grants alternate 0,1,0,1.
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            device_rvalid = 1'b0;
            host_req = 2'b11; host_addr[0] = 32'hA000_0000; host_addr[1] = 32'hB000_0000;
            device_gnt = 1'b1;
            #1;
            check("t2_gnt", 64'(host_gnt), 64'd1 << (k % 2));
            check("t2_daddr", 64'(device_addr), (k % 2 == 0) ? 64'hA000_0000 : 64'hB000_0000);
            @(negedge clk);
            tag = (k % 2 == 0) ? 32'hA000_00A5 : 32'hB000_00A5;
            device_rvalid = 1'b1; device_rdata = tag;
            push(k % 2, tag, 1'b0);
            #1;
            sample_rsp("t2_rsp", 1'b1);
            check("t2_wait_gnt", 64'(host_gnt), 64'h0);
        end

        // Reset while a response is outstanding.
        @(negedge clk);
        device_rvalid = 1'b0;
        #1 check("t6_gnt", 64'(host_gnt), 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_quiet("t6_rst_wait");
        @(negedge clk);
        device_rvalid = 1'b1; device_rdata = 32'h0000_6666;
        #1 check_quiet("t6_rst_late");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_post_gnt", 64'(host_gnt), 64'h1);
        sample_rsp("t6_post", 1'b0);
        @(negedge clk);
        host_req = '0; device_gnt = 1'b0; device_rdata = 32'h0000_C0DE;
        push(0, 32'h0000_C0DE, 1'b0);
        #1 sample_rsp("t6_rsp", 1'b1);

        @(negedge clk);
        clear_inputs();
        #1 check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
